// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded fields in, registered EX fields out.
// master = decode side, slave = the id_ex_stage register.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [RA_W-1:0] id_rd;
  logic [XLEN-1:0] id_imm;
  logic [2:0]      id_alu_op;
  logic            id_alu_src_imm;
  logic            id_reg_we;
  logic            id_mem_re;
  logic            id_mem_we;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_alu_a;
  logic [XLEN-1:0] ex_alu_b;
  logic [2:0]      ex_alu_op;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_we;
  logic            ex_mem_re;
  logic            ex_mem_we;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_imm, id_alu_op, id_alu_src_imm,
           id_reg_we, id_mem_re, id_mem_we,
    input  ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_alu_op,
           ex_store_data, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_imm, id_alu_op, id_alu_src_imm,
           id_reg_we, id_mem_re, id_mem_we,
    output ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_alu_op,
           ex_store_data, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and
// EX/MEM + MEM/WB operand forwarding for the RV32 EX stage.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  id_ex_if.slave          bus,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_we,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_data,
  output logic            hazard_stall
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [2:0]      op;
    logic            src_imm;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
  } id_ex_t;

  id_ex_t r;
  id_ex_t cap;

  function automatic logic hit(
    input logic            we,
    input logic [RA_W-1:0] rd,
    input logic [RA_W-1:0] rs
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

  logic ld_rs1;
  logic ld_rs2;

  assign ld_rs1 = bus.id_use_rs1 && (bus.id_rs1 == r.rd);
  assign ld_rs2 = bus.id_use_rs2 && (bus.id_rs2 == r.rd);

  assign hazard_stall = bus.id_valid && r.valid && r.mem_re
                     && (r.rd != '0) && (ld_rs1 || ld_rs2);

  // wb bypass at capture covers a register-file write in this same cycle
  always_comb begin
    cap         = '0;
    cap.valid   = bus.id_valid;
    cap.pc      = bus.id_pc;
    cap.rs1     = bus.id_rs1;
    cap.rs2     = bus.id_rs2;
    cap.rd      = bus.id_rd;
    cap.imm     = bus.id_imm;
    cap.op      = bus.id_alu_op;
    cap.src_imm = bus.id_alu_src_imm;
    cap.reg_we  = bus.id_reg_we & bus.id_valid;
    cap.mem_re  = bus.id_mem_re & bus.id_valid;
    cap.mem_we  = bus.id_mem_we & bus.id_valid;
    cap.a = hit(wb_reg_we, wb_rd, bus.id_rs1)
          ? wb_data : bus.id_rs1_data;
    cap.b = hit(wb_reg_we, wb_rd, bus.id_rs2)
          ? wb_data : bus.id_rs2_data;
  end

  // bubbles clear the whole entry so no stale rd can match downstream
  always_ff @(posedge clk) begin
    if (rst)               r <= '0;
    else if (flush_i)      r <= '0;
    else if (stall_i)      r <= r;
    else if (hazard_stall) r <= '0;
    else                   r <= cap;
  end

  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;

  always_comb begin
    fa = r.a;
    case (1'b1)
      hit(exm_reg_we, exm_rd, r.rs1): fa = exm_result;
      hit(wb_reg_we, wb_rd, r.rs1):   fa = wb_data;
      default:                        fa = r.a;
    endcase
  end

  always_comb begin
    fb = r.b;
    case (1'b1)
      hit(exm_reg_we, exm_rd, r.rs2): fb = exm_result;
      hit(wb_reg_we, wb_rd, r.rs2):   fb = wb_data;
      default:                        fb = r.b;
    endcase
  end

  assign bus.ex_valid      = r.valid;
  assign bus.ex_pc         = r.pc;
  assign bus.ex_alu_a      = fa;
  assign bus.ex_alu_b      = r.src_imm ? r.imm : fb;
  assign bus.ex_alu_op     = r.op;
  assign bus.ex_store_data = fb;
  assign bus.ex_rd         = r.rd;
  assign bus.ex_reg_we     = r.reg_we;
  assign bus.ex_mem_re     = r.mem_re;
  assign bus.ex_mem_we     = r.mem_we;

endmodule
